goal_score_keeper: RTL and testbench

//  Consumer of the per-pixel draw requests from the background drawer and the ball drawer.

---
 rtl/goal_score_keeper.sv | 136 +++++++++++++
 tb/tb_goal_score_keeper.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goal_score_keeper.sv
// Goal/border overlap detector, score keeper and game FSM; borderHit has 1-cycle latency, state/score outputs update the cycle after startOfFrame or goalAck.
// No backpressure: goalValid and goalByTeam are held until goalAck, and overlap requests are always consumed.
module goal_score_keeper #(
    parameter int WIN_SCORE       = 5,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       ballDrawReq,
    input  logic       boardersDrawReq,
    input  logic       teamGoalDrawReq,
    input  logic       oppGoalDrawReq,
    input  logic       gameRestart,
    input  logic       goalAck,
    output logic       borderHit,
    output logic       goalValid,
    output logic       goalByTeam,
    output logic [3:0] scoreTeam,
    output logic [3:0] scoreOpp,
    output logic       playActive,
    output logic       gameOver
);

    typedef enum logic [1:0] {
        PLAY         = 2'd0,
        GOAL_PENDING = 2'd1,
        COOLDOWN     = 2'd2,
        GAME_OVER    = 2'd3
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    localparam logic [7:0] CD  = 8'(COOLDOWN_FRAMES);

    state_t     state, stateNext;
    logic       oppHit, teamHit, oppHitNext, teamHitNext;
    logic [7:0] cdCount, cdCountNext;
    logic [3:0] scoreTeamNext, scoreOppNext;
    logic       goalValidNext, goalByTeamNext;
    logic       oppOverlap, teamOverlap;

    assign oppOverlap  = ballDrawReq & oppGoalDrawReq;
    assign teamOverlap = ballDrawReq & teamGoalDrawReq;

    always_comb begin
        stateNext      = state;
        cdCountNext    = cdCount;
        scoreTeamNext  = scoreTeam;
        scoreOppNext   = scoreOpp;
        goalValidNext  = goalValid;
        goalByTeamNext = goalByTeam;
        // Overlap on the startOfFrame cycle itself belongs to the frame that is starting.
        if (startOfFrame) begin
            oppHitNext  = oppOverlap;
            teamHitNext = teamOverlap;
        end else begin
            oppHitNext  = oppHit | oppOverlap;
            teamHitNext = teamHit | teamOverlap;
        end

        if (gameRestart) begin
            stateNext     = COOLDOWN;
            cdCountNext   = CD;
            scoreTeamNext = 4'd0;
            scoreOppNext  = 4'd0;
            goalValidNext = 1'b0;
            oppHitNext    = 1'b0;
            teamHitNext   = 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    if (startOfFrame && (oppHit ^ teamHit)) begin
                        stateNext      = GOAL_PENDING;
                        goalValidNext  = 1'b1;
                        goalByTeamNext = oppHit;
                        if (oppHit) begin
                            if (scoreTeam < WIN) scoreTeamNext = scoreTeam + 4'd1;
                        end else begin
                            if (scoreOpp < WIN) scoreOppNext = scoreOpp + 4'd1;
                        end
                    end
                end
                GOAL_PENDING: begin
                    if (goalAck) begin
                        goalValidNext = 1'b0;
                        if (scoreTeam == WIN || scoreOpp == WIN) begin
                            stateNext = GAME_OVER;
                        end else begin
                            stateNext   = COOLDOWN;
                            cdCountNext = CD;
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cdCount <= 8'd1) begin
                            stateNext   = PLAY;
                            cdCountNext = 8'd0;
                        end else begin
                            cdCountNext = cdCount - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLAY;
            oppHit     <= 1'b0;
            teamHit    <= 1'b0;
            cdCount    <= 8'd0;
            scoreTeam  <= 4'd0;
            scoreOpp   <= 4'd0;
            goalValid  <= 1'b0;
            goalByTeam <= 1'b0;
            borderHit  <= 1'b0;
        end else begin
            state      <= stateNext;
            oppHit     <= oppHitNext;
            teamHit    <= teamHitNext;
            cdCount    <= cdCountNext;
            scoreTeam  <= scoreTeamNext;
            scoreOpp   <= scoreOppNext;
            goalValid  <= goalValidNext;
            goalByTeam <= goalByTeamNext;
            borderHit  <= ballDrawReq & boardersDrawReq;
        end
    end

    assign playActive = (state == PLAY);
    assign gameOver   = (state == GAME_OVER);

endmodule

// File: tb/tb_goal_score_keeper.sv
// Directed bench for goal_score_keeper; status word = {goalValid, goalByTeam, playActive, gameOver, scoreTeam, scoreOpp}.
module tb_goal_score_keeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       ballDrawReq = 1'b0;
    logic       boardersDrawReq = 1'b0;
    logic       teamGoalDrawReq = 1'b0;
    logic       oppGoalDrawReq = 1'b0;
    logic       gameRestart = 1'b0;
    logic       goalAck = 1'b0;
    logic       borderHit;
    logic       goalValid;
    logic       goalByTeam;
    logic [3:0] scoreTeam;
    logic [3:0] scoreOpp;
    logic       playActive;
    logic       gameOver;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    goal_score_keeper #(.WIN_SCORE(5), .COOLDOWN_FRAMES(60)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .ballDrawReq(ballDrawReq),
        .boardersDrawReq(boardersDrawReq), .teamGoalDrawReq(teamGoalDrawReq),
        .oppGoalDrawReq(oppGoalDrawReq), .gameRestart(gameRestart), .goalAck(goalAck),
        .borderHit(borderHit), .goalValid(goalValid), .goalByTeam(goalByTeam),
        .scoreTeam(scoreTeam), .scoreOpp(scoreOpp), .playActive(playActive), .gameOver(gameOver)
    );

    logic [11:0] status;
    assign status = {goalValid, goalByTeam, playActive, gameOver, scoreTeam, scoreOpp};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic pix(input logic opp, input logic team, input logic brd);
        ballDrawReq = 1'b1;
        oppGoalDrawReq = opp;
        teamGoalDrawReq = team;
        boardersDrawReq = brd;
        tick();
        ballDrawReq = 1'b0;
        oppGoalDrawReq = 1'b0;
        teamGoalDrawReq = 1'b0;
        boardersDrawReq = 1'b0;
    endtask

    task automatic ack_and_cooldown();
        goalAck = 1'b1;
        tick();
        goalAck = 1'b0;
        repeat (60) begin
            idle(2);
            do_sof();
        end
        idle(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        vectors++;
        if ({status, borderHit} !== {12'b0010_0000_0000, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got %h/%b want 200/0", status, borderHit);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_goal_hold();
        do_sof();
        repeat (3) pix(1'b1, 1'b0, 1'b0);
        idle(1);
        do_sof();
        vectors++;
        if (status !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL team_goal got %h want %h", status, {1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0});
        end
        for (int i = 0; i < 100; i++) begin
            if (i % 10 == 3) startOfFrame = 1'b1;
            if (i % 10 == 5) begin ballDrawReq = 1'b1; teamGoalDrawReq = 1'b1; end
            tick();
            startOfFrame = 1'b0; ballDrawReq = 1'b0; teamGoalDrawReq = 1'b0;
        end
        vectors++;
        if (status !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL goal_hold got %h want %h", status, {1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0});
        end
    endtask

    task automatic test_cooldown();
        goalAck = 1'b1;
        tick();
        goalAck = 1'b0;
        vectors++;
        if (status !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL ack_clear got %h want %h", status, {1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0});
        end
        for (int k = 1; k <= 59; k++) begin
            pix(1'b0, 1'b1, 1'b0);
            idle(1);
            do_sof();
            vectors++;
            if ({goalValid, playActive} !== 2'b00) begin
                miscompares++;
                $display("FAIL cooldown_frame%0d got vld/play %b%b want 00", k, goalValid, playActive);
            end
        end
        pix(1'b0, 1'b1, 1'b0);
        idle(1);
        do_sof();
        vectors++;
        if ({goalValid, playActive} !== 2'b01) begin
            miscompares++;
            $display("FAIL cooldown_exit got vld/play %b%b want 01", goalValid, playActive);
        end
        pix(1'b0, 1'b1, 1'b0);
        idle(1);
        do_sof();
        vectors++;
        if (status !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1}) begin
            miscompares++;
            $display("FAIL opp_goal_f61 got %h want %h", status, {1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1});
        end
        ack_and_cooldown();
    endtask

    task automatic test_sof_boundary();
        startOfFrame = 1'b1;
        pix(1'b0, 1'b1, 1'b0);
        startOfFrame = 1'b0;
        vectors++;
        if (goalValid !== 1'b0) begin
            miscompares++;
            $display("FAIL sof_overlap_early got goalValid %b want 0", goalValid);
        end
        idle(3);
        do_sof();
        vectors++;
        if (status !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2}) begin
            miscompares++;
            $display("FAIL sof_overlap_next got %h want %h", status, {1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2});
        end
        ack_and_cooldown();
    endtask

    task automatic test_ambiguous();
        pix(1'b1, 1'b0, 1'b0);
        pix(1'b0, 1'b1, 1'b0);
        idle(1);
        do_sof();
        vectors++;
        if (status !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2}) begin
            miscompares++;
            $display("FAIL ambiguous got %h want %h", status, {1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2});
        end
        idle(2);
        do_sof();
        vectors++;
        if (status !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2}) begin
            miscompares++;
            $display("FAIL latch_cleared got %h want %h", status, {1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2});
        end
    endtask

    task automatic test_border_play();
        pix(1'b0, 1'b0, 1'b1);
        vectors++;
        if (borderHit !== 1'b1) begin
            miscompares++;
            $display("FAIL border_play_n1 got %b want 1", borderHit);
        end
        tick();
        vectors++;
        if (borderHit !== 1'b0) begin
            miscompares++;
            $display("FAIL border_play_n2 got %b want 0", borderHit);
        end
        boardersDrawReq = 1'b1;
        tick();
        boardersDrawReq = 1'b0;
        vectors++;
        if (borderHit !== 1'b0) begin
            miscompares++;
            $display("FAIL border_noball got %b want 0", borderHit);
        end
    endtask

    task automatic test_game_over();
        for (int s = 3; s <= 4; s++) begin
            pix(1'b0, 1'b1, 1'b0);
            do_sof();
            vectors++;
            if (status !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'(s)}) begin
                miscompares++;
                $display("FAIL opp_score%0d got %h want %h", s, status, {1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'(s)});
            end
            ack_and_cooldown();
        end
        pix(1'b0, 1'b1, 1'b0);
        do_sof();
        goalAck = 1'b1;
        tick();
        goalAck = 1'b0;
        vectors++;
        if (status !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd5}) begin
            miscompares++;
            $display("FAIL game_over got %h want %h", status, {1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd5});
        end
        repeat (3) begin
            pix(1'b1, 1'b0, 1'b0);
            do_sof();
            goalAck = 1'b1;
            tick();
            goalAck = 1'b0;
        end
        vectors++;
        if (status !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd5}) begin
            miscompares++;
            $display("FAIL game_over_frozen got %h want %h", status, {1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd5});
        end
        pix(1'b0, 1'b0, 1'b1);
        vectors++;
        if (borderHit !== 1'b1) begin
            miscompares++;
            $display("FAIL border_gameover_n1 got %b want 1", borderHit);
        end
        tick();
        vectors++;
        if (borderHit !== 1'b0) begin
            miscompares++;
            $display("FAIL border_gameover_n2 got %b want 0", borderHit);
        end
        gameRestart = 1'b1;
        tick();
        gameRestart = 1'b0;
        vectors++;
        if (status !== {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL restart_from_over got %h want 000", status);
        end
        repeat (59) begin
            idle(2);
            do_sof();
        end
        vectors++;
        if (playActive !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_cd59 got playActive %b want 0", playActive);
        end
        idle(2);
        do_sof();
        vectors++;
        if (playActive !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_cd60 got playActive %b want 1", playActive);
        end
    endtask

    task automatic test_restart_priority();
        pix(1'b1, 1'b0, 1'b0);
        do_sof();
        vectors++;
        if (status !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL prio_setup got %h want %h", status, {1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0});
        end
        gameRestart = 1'b1;
        goalAck = 1'b1;
        startOfFrame = 1'b1;
        tick();
        gameRestart = 1'b0;
        goalAck = 1'b0;
        startOfFrame = 1'b0;
        vectors++;
        if ({goalValid, playActive, gameOver, scoreTeam, scoreOpp} !== 11'b0) begin
            miscompares++;
            $display("FAIL restart_beats_ack got %h want 000", status);
        end
        repeat (5) begin
            idle(2);
            do_sof();
        end
        ballDrawReq = 1'b1;
        boardersDrawReq = 1'b1;
        reset = 1'b1;
        tick();
        ballDrawReq = 1'b0;
        boardersDrawReq = 1'b0;
        reset = 1'b0;
        vectors++;
        if ({status, borderHit} !== {12'b0010_0000_0000, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_cooldown got %h/%b want 200/0", status, borderHit);
        end
        pix(1'b0, 1'b1, 1'b0);
        do_sof();
        vectors++;
        if (status !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1}) begin
            miscompares++;
            $display("FAIL play_after_reset got %h want %h", status, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1});
        end
    endtask

    initial begin
        test_reset();
        test_goal_hold();
        test_cooldown();
        test_sof_boundary();
        test_ambiguous();
        test_border_play();
        test_game_over();
        test_restart_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
